// File: rtl/rojobot_regs_pkg.sv
// Register map constants and bus FSM encoding for the Rojobot Wishbone register bank.
package rojobot_regs_pkg;

    localparam logic [31:0] WIN_STRIDE = 32'h20;
    localparam logic [31:0] GLB_BASE   = 32'h100;
    localparam logic [15:0] ID_TAG     = 16'h0B07;
    localparam int          OVR_W      = 8;

    // Word offsets inside a bot window (byte offset >> 2)
    localparam logic [2:0] REG_INFO   = 3'd0;
    localparam logic [2:0] REG_CTRL   = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_ACK    = 3'd3;

    // Word offsets inside the global window at GLB_BASE
    localparam logic [5:0] GLB_PEND = 6'd0;
    localparam logic [5:0] GLB_MASK = 6'd1;
    localparam logic [5:0] GLB_ID   = 6'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_ERR  = 2'd2
    } bus_state_t;

endpackage

// File: rtl/rojobot_bot_channel.sv
// One Rojobot channel: update-edge detect, coherent INFO snapshot, pending flag and
// saturating overrun counter.
module rojobot_bot_channel
    import rojobot_regs_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             upd,
    input  logic [31:0]      info,
    input  logic             ack_clr,
    output logic [31:0]      snap,
    output logic             pend,
    output logic [OVR_W-1:0] ovr
);

    logic upd_q;
    logic upd_edge;

    assign upd_edge = upd & ~upd_q;

    // An edge coinciding with an ACK wins for pending but the overrun count is cleared.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            upd_q <= 1'b0;
            snap  <= '0;
            pend  <= 1'b0;
            ovr   <= '0;
        end else begin
            upd_q <= upd;
            if (upd_edge) begin
                snap <= info;
            end
            if (upd_edge) begin
                pend <= 1'b1;
            end else if (ack_clr) begin
                pend <= 1'b0;
            end
            if (ack_clr) begin
                ovr <= '0;
            end else if (upd_edge && pend && (ovr != '1)) begin
                ovr <= ovr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rojobot_wb_regbank.sv
// Classic-cycle Wishbone slave serving NUM_BOTS Rojobot channels: decode, ack/err FSM,
// CTRL and IRQ_MASK registers, read mux and aggregated interrupt.
module rojobot_wb_regbank
    import rojobot_regs_pkg::*;
#(
    parameter int         NUM_BOTS = 2,
    parameter logic [7:0] CTRL_RST = 8'h00
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [31:0]             wb_adr_i,
    input  logic [31:0]             wb_dat_i,
    input  logic [3:0]              wb_sel_i,
    input  logic                    wb_we_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic [2:0]              wb_cti_i,
    input  logic [1:0]              wb_bte_i,
    output logic [31:0]             wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic                    wb_rtry_o,
    input  logic [32*NUM_BOTS-1:0]  bot_info_i,
    input  logic [NUM_BOTS-1:0]     upd_sysregs_i,
    output logic [8*NUM_BOTS-1:0]   bot_ctrl_o,
    output logic                    irq_o
);

    bus_state_t                 state_q, state_d;
    logic                       req, ok, wr_go, mask_we;
    logic [31:0]                rd_data;
    logic [NUM_BOTS-1:0]        bot_hit, ctrl_we, ack_clr, pend_vec, mask_q;
    logic [32*NUM_BOTS-1:0]     snap_flat;
    logic [OVR_W*NUM_BOTS-1:0]  ovr_flat;
    logic [8*NUM_BOTS-1:0]      ctrl_q;
    logic                       unused_bits;

    assign unused_bits = ^{wb_adr_i[31:9], wb_adr_i[1:0], wb_dat_i[31:8],
                           wb_sel_i[3:1], wb_cti_i, wb_bte_i};

    // A new request is only accepted while no termination is being presented.
    assign req   = wb_cyc_i & wb_stb_i & (state_q == ST_IDLE);
    assign wr_go = req & ok & wb_we_i & wb_sel_i[0];

    always_comb begin
        state_d = ST_IDLE;
        if (state_q == ST_IDLE && req) begin
            state_d = ok ? ST_ACK : ST_ERR;
        end
    end

    // Address bit 8 selects the global window at GLB_BASE; below it are the bot windows.
    always_comb begin
        ok      = 1'b0;
        rd_data = '0;
        bot_hit = '0;
        if (wb_adr_i[8]) begin
            case (wb_adr_i[7:2])
                GLB_PEND: begin ok = ~wb_we_i; rd_data = 32'(pend_vec); end
                GLB_MASK: begin ok = 1'b1;     rd_data = 32'(mask_q);   end
                GLB_ID:   begin ok = ~wb_we_i; rd_data = {ID_TAG, 8'h00, 8'(NUM_BOTS)}; end
                default:  ;
            endcase
        end else begin
            for (int n = 0; n < NUM_BOTS; n++) begin
                if (wb_adr_i[7:5] == 3'(n)) begin
                    bot_hit[n] = 1'b1;
                    case (wb_adr_i[4:2])
                        REG_INFO:   begin ok = ~wb_we_i; rd_data = snap_flat[32*n +: 32]; end
                        REG_CTRL:   begin ok = 1'b1;     rd_data = {24'h0, ctrl_q[8*n +: 8]}; end
                        REG_STATUS: begin
                            ok      = ~wb_we_i;
                            rd_data = {16'h0, ovr_flat[OVR_W*n +: OVR_W], 7'h0, pend_vec[n]};
                        end
                        REG_ACK:    ok = 1'b1;
                        default:    ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        mask_we = wr_go & wb_adr_i[8] & (wb_adr_i[7:2] == GLB_MASK);
        ctrl_we = '0;
        ack_clr = '0;
        for (int n = 0; n < NUM_BOTS; n++) begin
            ctrl_we[n] = wr_go & bot_hit[n] & (wb_adr_i[4:2] == REG_CTRL);
            ack_clr[n] = wr_go & bot_hit[n] & (wb_adr_i[4:2] == REG_ACK) & wb_dat_i[0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            wb_dat_o <= '0;
            ctrl_q   <= {NUM_BOTS{CTRL_RST}};
            mask_q   <= '0;
            irq_o    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wb_dat_o <= (req && ok && !wb_we_i) ? rd_data : '0;
            if (mask_we) begin
                mask_q <= wb_dat_i[NUM_BOTS-1:0];
            end
            for (int n = 0; n < NUM_BOTS; n++) begin
                if (ctrl_we[n]) begin
                    ctrl_q[8*n +: 8] <= wb_dat_i[7:0];
                end
            end
            irq_o <= |(pend_vec & mask_q);
        end
    end

    assign wb_ack_o   = (state_q == ST_ACK);
    assign wb_err_o   = (state_q == ST_ERR);
    assign wb_rtry_o  = 1'b0;
    assign bot_ctrl_o = ctrl_q;

    for (genvar n = 0; n < NUM_BOTS; n++) begin : g_bot
        rojobot_bot_channel u_chan (
            .clk     (clk),
            .rstn    (rstn),
            .upd     (upd_sysregs_i[n]),
            .info    (bot_info_i[32*n +: 32]),
            .ack_clr (ack_clr[n]),
            .snap    (snap_flat[32*n +: 32]),
            .pend    (pend_vec[n]),
            .ovr     (ovr_flat[OVR_W*n +: OVR_W])
        );
    end

endmodule

// File: tb/tb_rojobot_wb_regbank.sv
// Scoreboard bench for rojobot_wb_regbank: directed register-map cases plus randomized
// traffic checked against an address-level model of the register bank.
module tb_rojobot_wb_regbank;

    localparam int         NB   = 2;
    localparam logic [7:0] CRST = 8'h00;

    logic              clk = 1'b0;
    logic              rstn;
    logic [31:0]       wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]        wb_sel_i;
    logic              wb_we_i, wb_cyc_i, wb_stb_i;
    logic [2:0]        wb_cti_i;
    logic [1:0]        wb_bte_i;
    logic              wb_ack_o, wb_err_o, wb_rtry_o, irq_o;
    logic [32*NB-1:0]  bot_info_i;
    logic [NB-1:0]     upd_sysregs_i;
    logic [8*NB-1:0]   bot_ctrl_o;

    rojobot_wb_regbank #(.NUM_BOTS(NB), .CTRL_RST(CRST)) dut (
        .clk(clk), .rstn(rstn), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .wb_err_o(wb_err_o), .wb_rtry_o(wb_rtry_o), .bot_info_i(bot_info_i),
        .upd_sysregs_i(upd_sysregs_i), .bot_ctrl_o(bot_ctrl_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    // Entry: {is_read, expect_err, read_data}
    logic [33:0] exp_q[$];

    // Reference model state
    logic [7:0]    ctrl_m [NB];
    logic [31:0]   snap_m [NB];
    int            ovr_m  [NB];
    logic [NB-1:0] pend_m;
    logic [NB-1:0] mask_m;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int b = 0; b < NB; b++) begin
            ctrl_m[b] = CRST; snap_m[b] = '0; ovr_m[b] = 0;
        end
        pend_m = '0;
        mask_m = '0;
    endfunction

    function automatic logic [8*NB-1:0] ctrl_packed();
        logic [8*NB-1:0] v;
        for (int b = 0; b < NB; b++) v[8*b +: 8] = ctrl_m[b];
        return v;
    endfunction

    function automatic void model_edge(input int b, input logic [31:0] info);
        if (pend_m[b]) ovr_m[b] = (ovr_m[b] >= 255) ? 255 : ovr_m[b] + 1;
        pend_m[b] = 1'b1;
        snap_m[b] = info;
    endfunction

    // Byte-address view of the register map
    function automatic void model_bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                      input logic [3:0] sel, output logic err, output logic [31:0] rd);
        int a, b, off;
        a   = int'(adr & 32'h1FC);
        err = 1'b1;
        rd  = '0;
        if (a >= 'h100) begin
            case (a)
                'h100: if (!we) begin err = 0; rd = 32'(pend_m); end
                'h104: begin
                    err = 0; rd = 32'(mask_m);
                    if (we && sel[0]) mask_m = dat[NB-1:0];
                end
                'h108: if (!we) begin err = 0; rd = {16'h0B07, 8'h00, 8'(NB)}; end
                default: ;
            endcase
        end else begin
            b   = a / 32;
            off = a % 32;
            if (b < NB) begin
                case (off)
                    0:  if (!we) begin err = 0; rd = snap_m[b]; end
                    4:  begin
                        err = 0; rd = {24'h0, ctrl_m[b]};
                        if (we && sel[0]) ctrl_m[b] = dat[7:0];
                    end
                    8:  if (!we) begin err = 0; rd = {16'h0, 8'(ovr_m[b]), 7'h0, pend_m[b]}; end
                    12: begin
                        err = 0;
                        if (we && sel[0] && dat[0]) begin pend_m[b] = 1'b0; ovr_m[b] = 0; end
                    end
                    default: ;
                endcase
            end
        end
    endfunction

    task automatic check_outputs();
        @(negedge clk);
        cmp("irq", 64'(irq_o), 64'(|(pend_m & mask_m)));
        cmp("bot_ctrl", 64'(bot_ctrl_o), 64'(ctrl_packed()));
    endtask

    // One classic cycle; optionally raises an update edge on bot ub in the request cycle.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int ub, input logic [31:0] uinfo);
        logic        e_err;
        logic [31:0] e_rd;
        model_bus(we, adr, dat, sel, e_err, e_rd);
        if (ub >= 0) model_edge(ub, uinfo);
        exp_q.push_back({~we, e_err, e_rd});
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        wb_cti_i = 3'($urandom_range(0, 7)); wb_bte_i = 2'($urandom_range(0, 3));
        if (ub >= 0) begin
            bot_info_i[32*ub +: 32] = uinfo;
            upd_sysregs_i[ub] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        cmp("term_latency", 64'(wb_ack_o | wb_err_o), 64'd1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        upd_sysregs_i = '0;
        check_outputs();
    endtask

    task automatic rd(input logic [31:0] adr);
        xfer(1'b0, adr, 32'($urandom), 4'hF, -1, 32'h0);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        xfer(1'b1, adr, dat, sel, -1, 32'h0);
    endtask

    task automatic pulse(input int b, input logic [31:0] info);
        logic irq_before;
        irq_before = |(pend_m & mask_m);
        bot_info_i[32*b +: 32] = info;
        upd_sysregs_i[b] = 1'b1;
        @(negedge clk);
        cmp("irq_lag", 64'(irq_o), 64'(irq_before));
        upd_sysregs_i[b] = 1'b0;
        model_edge(b, info);
        check_outputs();
    endtask

    // Bus monitor: every termination consumes one expected entry.
    always @(negedge clk) begin
        logic [33:0] e;
        if (rstn && (wb_ack_o || wb_err_o)) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL spurious_term: got ack=%b err=%b expected no termination", wb_ack_o, wb_err_o);
            end else begin
                e = exp_q.pop_front();
                cmp("ack_err", 64'({wb_ack_o, wb_err_o}), e[32] ? 64'b01 : 64'b10);
                if (e[33] && !e[32]) cmp("rdata", 64'(wb_dat_o), 64'(e[31:0]));
            end
        end
    end

    localparam int NADR = 12;
    logic [31:0] adr_tab [NADR] = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h020, 32'h024,
                                    32'h028, 32'h02C, 32'h100, 32'h104, 32'h108, 32'h040};

    initial begin
        rstn = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = '0; wb_bte_i = '0;
        bot_info_i = '0; upd_sysregs_i = '0;
        model_reset();
        repeat (3) @(negedge clk);
        cmp("rst_ack", 64'(wb_ack_o), 64'd0);
        cmp("rst_err", 64'(wb_err_o), 64'd0);
        cmp("rst_dat", 64'(wb_dat_o), 64'd0);
        cmp("rst_irq", 64'(irq_o), 64'd0);
        cmp("rst_rtry", 64'(wb_rtry_o), 64'd0);
        cmp("rst_ctrl", 64'(bot_ctrl_o), 64'({NB{CRST}}));
        rstn = 1'b1;
        @(negedge clk);

        rd(32'h108);
        wr(32'h024, 32'h0000_00A5, 4'b0001);
        wr(32'h024, 32'h0000_005A, 4'b1110);
        rd(32'h024);

        pulse(0, 32'h1020_3040);
        rd(32'h000);
        rd(32'h008);
        wr(32'h104, 32'h1, 4'b0001);
        wr(32'h00C, 32'h1, 4'b0001);
        rd(32'h100);

        for (int i = 0; i < 3; i++) pulse(1, 32'(i) + 32'hBEEF_0000);
        rd(32'h028);
        rd(32'h020);
        for (int i = 0; i < 297; i++) pulse(1, 32'($urandom));
        rd(32'h028);

        pulse(0, 32'h0000_1111);
        pulse(0, 32'h0000_2222);
        xfer(1'b1, 32'h00C, 32'h1, 4'b0001, 0, 32'h0000_3333);
        rd(32'h008);
        rd(32'h000);

        rd(32'h040);
        rd(32'h010);
        wr(32'h000, 32'hDEAD_BEEF, 4'hF);
        wr(32'h108, 32'h0, 4'hF);
        wr(32'h008, 32'hFFFF_FFFF, 4'hF);
        rd(32'h000);
        rd(32'h00C);

        // Held strobe: two terminations in four cycles
        for (int i = 0; i < 2; i++) exp_q.push_back({1'b1, 1'b0, 16'h0B07, 8'h00, 8'(NB)});
        wb_adr_i = 32'h108; wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        check_outputs();

        for (int i = 0; i < 250; i++) begin
            int          r, ub;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            if (r < 3) begin
                pulse($urandom_range(0, NB - 1), 32'($urandom));
            end else begin
                if ($urandom_range(0, 1) == 1) a = adr_tab[$urandom_range(0, NADR - 1)];
                else a = 32'($urandom_range(0, 32'h1FF));
                a  = a | (32'($urandom) & 32'hFFFF_FE03);
                ub = ($urandom_range(0, 7) == 0) ? $urandom_range(0, NB - 1) : -1;
                xfer(1'($urandom_range(0, 1)), a, 32'($urandom), 4'($urandom_range(0, 15)),
                     ub, 32'($urandom));
            end
        end

        // Reset asserted while a request is pending aborts it
        wb_adr_i = 32'h108; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        rstn = 1'b0;
        @(negedge clk);
        cmp("abort_ack", 64'(wb_ack_o), 64'd0);
        cmp("abort_err", 64'(wb_err_o), 64'd0);
        cmp("abort_ctrl", 64'(bot_ctrl_o), 64'({NB{CRST}}));
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        rstn = 1'b1;
        model_reset();
        check_outputs();
        rd(32'h104);
        rd(32'h024);
        rd(32'h008);
        rd(32'h020);

        repeat (3) @(negedge clk);
        cmp("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
